// File: rtl/average_decimator.sv
// Accumulate-and-dump decimator: averages N = 2^LOG2_N enabled samples per output strobe.
// Define AVERAGE_DECIMATOR_ROUNDING_EN to round half toward +inf instead of truncating.
module average_decimator #(
   parameter int unsigned IW     = 8,
   parameter int unsigned LOG2_N = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          i_ce,
   input  logic [IW-1:0] data_in,
   output logic [IW-1:0] data_out,
   output logic          o_ce
);

   localparam int unsigned AW = IW + LOG2_N;
   localparam logic [LOG2_N-1:0] CntLast = '1;

   logic signed [AW-1:0] acc_q, acc_d;
   logic signed [AW-1:0] sum, sum_adj, shifted;
   logic [LOG2_N-1:0]    cnt_q, cnt_d;
   logic [IW-1:0]        dout_q, dout_d;
   logic                 oce_q, oce_d;

   always_comb begin
      sum = acc_q + signed'({{LOG2_N{data_in[IW-1]}}, data_in});
`ifdef AVERAGE_DECIMATOR_ROUNDING_EN
      // Bias by N/2 so the floor shift rounds half toward +inf; cannot overflow AW bits.
      sum_adj = sum + signed'(AW'(1) << (LOG2_N - 1));
`else
      sum_adj = sum;
`endif
      shifted = sum_adj >>> LOG2_N;

      acc_d  = acc_q;
      cnt_d  = cnt_q;
      dout_d = dout_q;
      oce_d  = 1'b0;
      if (i_ce) begin
         if (cnt_q == CntLast) begin
            acc_d  = '0;
            cnt_d  = '0;
            dout_d = shifted[IW-1:0];
            oce_d  = 1'b1;
         end else begin
            acc_d = sum;
            cnt_d = cnt_q + LOG2_N'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         acc_q  <= '0;
         cnt_q  <= '0;
         dout_q <= '0;
         oce_q  <= 1'b0;
      end else begin
         acc_q  <= acc_d;
         cnt_q  <= cnt_d;
         dout_q <= dout_d;
         oce_q  <= oce_d;
      end
   end

   assign data_out = dout_q;
   assign o_ce     = oce_q;

endmodule

// File: tb/tb_average_decimator.sv
// Directed self-checking bench for average_decimator (IW=8, LOG2_N=2).
// Expected values follow the AVERAGE_DECIMATOR_ROUNDING_EN setting of the build.
module tb_average_decimator;

   logic       clk = 1'b0;
   logic       reset;
   logic       i_ce;
   logic [7:0] data_in;
   logic [7:0] data_out;
   logic       o_ce;

   int n_cmp = 0;
   int n_err = 0;

   average_decimator #(
      .IW     (8),
      .LOG2_N (2)
   ) u_dut (
      .clk      (clk),
      .reset    (reset),
      .i_ce     (i_ce),
      .data_in  (data_in),
      .data_out (data_out),
      .o_ce     (o_ce)
   );

   always #5 clk = ~clk;

`ifdef AVERAGE_DECIMATOR_ROUNDING_EN
   localparam bit Round = 1'b1;
`else
   localparam bit Round = 1'b0;
`endif

   task automatic check_eq(input string tag, input logic signed [31:0] obs,
                           input logic signed [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Drive one cycle's inputs at the falling edge; return 1 ns after the rising edge.
   task automatic step(input logic rst, input logic ce, input int d);
      @(negedge clk);
      reset   = rst;
      i_ce    = ce;
      data_in = 8'(d);
      @(posedge clk);
      #1;
   endtask

   task automatic frame(input string tag, input int s0, input int s1, input int s2,
                        input int s3, input int exp);
      logic signed [31:0] prev;
      prev = $signed(data_out);
      step(1'b0, 1'b1, s0);
      check_eq({tag, "_oce0"}, 32'(o_ce), 0);
      step(1'b0, 1'b1, s1);
      step(1'b0, 1'b1, s2);
      check_eq({tag, "_hold"}, $signed(data_out), prev);
      check_eq({tag, "_oce2"}, 32'(o_ce), 0);
      step(1'b0, 1'b1, s3);
      check_eq({tag, "_oce"}, 32'(o_ce), 1);
      check_eq({tag, "_out"}, $signed(data_out), exp);
      step(1'b0, 1'b0, 99);
      check_eq({tag, "_pulse1"}, 32'(o_ce), 0);
      check_eq({tag, "_keep"}, $signed(data_out), exp);
   endtask

   initial begin
      reset   = 1'b1;
      i_ce    = 1'b0;
      data_in = '0;
      step(1'b1, 1'b0, 0);
      step(1'b1, 1'b1, 55);
      check_eq("rst_out", $signed(data_out), 0);
      check_eq("rst_oce", 32'(o_ce), 0);

      frame("const10", 10, 10, 10, 10, 10);
      frame("mix1", 10, -20, 30, -40, -5);
      frame("mix2", 50, 0, 100, -128, Round ? 6 : 5);
      frame("rnd_pos", 1, 1, 2, 2, Round ? 2 : 1);
      frame("rnd_neg", -1, -1, -1, -2, Round ? -1 : -2);
      frame("max", 127, 127, 127, 127, 127);
      frame("min", -128, -128, -128, -128, -128);

      // Gapped enable: idle cycles carry junk data that must be ignored.
      step(1'b0, 1'b1, 4);
      step(1'b0, 1'b0, 99);
      step(1'b0, 1'b1, 8);
      step(1'b0, 1'b0, 99);
      step(1'b0, 1'b0, 99);
      step(1'b0, 1'b1, 12);
      step(1'b0, 1'b0, 99);
      step(1'b0, 1'b0, 99);
      step(1'b0, 1'b0, 99);
      check_eq("gap_oce", 32'(o_ce), 0);
      check_eq("gap_hold", $signed(data_out), -128);
      step(1'b0, 1'b1, 16);
      check_eq("gap_dump_oce", 32'(o_ce), 1);
      check_eq("gap_out", $signed(data_out), 10);
      step(1'b0, 1'b0, 99);
      step(1'b0, 1'b0, 99);
      check_eq("gap_after_oce", 32'(o_ce), 0);
      check_eq("gap_after_out", $signed(data_out), 10);

      // Reset mid-frame, with i_ce high during reset to exercise reset priority.
      step(1'b0, 1'b1, 100);
      step(1'b0, 1'b1, 100);
      step(1'b1, 1'b1, 100);
      check_eq("mid_rst_out", $signed(data_out), 0);
      check_eq("mid_rst_oce", 32'(o_ce), 0);
      frame("post_rst", 8, 8, 8, 8, 8);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
